// File: rtl/pll_cen_gen.sv
// N-channel fractional clock-enable generator in the refclk domain.
// Optional divclk square-wave outputs are built when PLL_CEN_GEN_DIVCLK_EN is defined.
module pll_cen_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = {32'h8A3D70A4, 32'h80000000}
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [2:0]          cfg_sel,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic                cfg_busy,
    output logic [CHANNELS-1:0] cen,
    output logic                locked
`ifdef PLL_CEN_GEN_DIVCLK_EN
    ,
    output logic [CHANNELS-1:0] divclk
`endif
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       CH_LIM    = 4'(CHANNELS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LOCK_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [ACC_W-1:0]    acc      [CHANNELS];
    logic [ACC_W-1:0]    inc      [CHANNELS];
    logic [ACC_W-1:0]    pend_inc [CHANNELS];
    logic [ACC_W-1:0]    acc_sum  [CHANNELS];
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] pend_nxt;
    logic [CHANNELS-1:0] carry;
    logic [CHANNELS-1:0] apply;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] cen_p1;
    logic                busy_p1;
    logic                locked_p1;
    logic                sync_p1;
    logic                wr_ok;
    logic [CNT_W-1:0]    lock_cnt;

    assign wr_ok = cfg_wr && ({1'b0, cfg_sel} < CH_LIM);

    // Stage p0: accumulate, decode writes, decide when a pending increment lands
    always_comb begin
        carry    = '0;
        apply    = '0;
        wr_hit   = '0;
        pend_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            acc_sum[i] = '0;
            {carry[i], acc_sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
            wr_hit[i]   = wr_ok && (cfg_sel == 3'(i));
            // Swap only on a pulse boundary so no period is ever shortened;
            // a stopped channel has no boundary, and sync realigns anyway.
            apply[i]    = pend[i] && (carry[i] || (inc[i] == '0) || sync || sync_p1);
            pend_nxt[i] = wr_hit[i] || (pend[i] && !apply[i]);
        end
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
            end
            pend      <= '0;
            cen_p1    <= '0;
            busy_p1   <= 1'b0;
            locked_p1 <= 1'b0;
            lock_cnt  <= '0;
            sync_p1   <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= sync ? '0 : acc_sum[i];
                if (apply[i])
                    inc[i] <= pend_inc[i];
            end
            pend    <= pend_nxt;
            cen_p1  <= sync ? '0 : carry;
            busy_p1 <= |pend_nxt;
            sync_p1 <= sync;
            if (wr_ok || sync || busy_p1) begin
                lock_cnt  <= '0;
                locked_p1 <= 1'b0;
            end else begin
                lock_cnt <= sat_inc(lock_cnt);
                if (lock_cnt == LOCK_LAST)
                    locked_p1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit[i])
                pend_inc[i] <= cfg_inc;
        end
    end

    assign cen      = cen_p1;
    assign cfg_busy = busy_p1;
    assign locked   = locked_p1;

`ifdef PLL_CEN_GEN_DIVCLK_EN
    logic [CHANNELS-1:0] divclk_p1;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            divclk_p1 <= '0;
        else if (sync)
            divclk_p1 <= '0;
        else
            divclk_p1 <= divclk_p1 ^ cen_p1;
    end

    assign divclk = divclk_p1;
`endif

endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed bench for pll_cen_gen with default parameters (also covers divclk
// when PLL_CEN_GEN_DIVCLK_EN is defined).
module tb_pll_cen_gen;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic        cfg_wr;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_inc;
    logic        cfg_busy;
    logic [1:0]  cen;
    logic        locked;
`ifdef PLL_CEN_GEN_DIVCLK_EN
    logic [1:0]  divclk;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pll_cen_gen dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .sync     (sync),
        .cfg_wr   (cfg_wr),
        .cfg_sel  (cfg_sel),
        .cfg_inc  (cfg_inc),
        .cfg_busy (cfg_busy),
        .cen      (cen),
        .locked   (locked)
`ifdef PLL_CEN_GEN_DIVCLK_EN
        ,
        .divclk   (divclk)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    initial begin
        int          cnt;
        logic [10:0] seq11;
        logic [15:0] seq16;

        rst_n = 1'b0; sync = 1'b0; cfg_wr = 1'b0; cfg_sel = '0; cfg_inc = '0;
        tick(); tick();
        chk("rst_cen", cen, 2'b00);
        chk("rst_locked", locked, 1'b0);
        chk("rst_busy", cfg_busy, 1'b0);
`ifdef PLL_CEN_GEN_DIVCLK_EN
        chk("rst_divclk", divclk, 2'b00);
`endif
        rst_n = 1'b1;

        // Free run from reset: edge k counted from release
        cnt = 0;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            cnt += int'(cen[1]);
            if (k <= 8) begin
                chk("ch0_phase", cen[0], 1'((k % 2) == 0));
`ifdef PLL_CEN_GEN_DIVCLK_EN
                chk("divclk_phase", divclk[0], 1'(((k - 1) >> 1) & 1));
`endif
            end
            if (k == 1023) chk("lock_1023", locked, 1'b0);
            if (k == 1024) chk("lock_1024", locked, 1'b1);
        end
        chk("ch1_count", cnt, 5400);
        chk("lock_hold", locked, 1'b1);

        // Two syncs; the second lands on a ch1 carry
        sync = 1'b1; tick(); sync = 1'b0;
        chk("syncA_cen", cen, 2'b00);
        chk("syncA_locked", locked, 1'b0);
        tick();
        chk("syncA1_cen", cen, 2'b00);
        sync = 1'b1; tick(); sync = 1'b0;
        chk("syncB_cen", cen, 2'b00);
`ifdef PLL_CEN_GEN_DIVCLK_EN
        chk("syncB_divclk", divclk, 2'b00);
`endif
        tick();
        chk("syncB1_cen", cen, 2'b00);
        tick();
        chk("syncB2_cen", cen, 2'b11);

        // Glitch-free apply on ch0 written mid-period
        tick();
        cfg_wr = 1'b1; cfg_sel = 3'd0; cfg_inc = 32'h4000_0000;
        seq11 = '0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin
                cfg_wr = 1'b0;
                chk("glitch_busy_set", cfg_busy, 1'b1);
            end
            if (k == 3) chk("glitch_busy_clr", cfg_busy, 1'b0);
            seq11 = {seq11[9:0], cen[0]};
        end
        chk("glitch_seq", seq11, 11'b10100010001);

        // Overwrite on ch1 before its boundary, then an out-of-range write
        sync = 1'b1; tick(); sync = 1'b0;
        tick();
        cfg_wr = 1'b1; cfg_sel = 3'd1; cfg_inc = 32'h1000_0000;
        tick();
        cfg_inc = 32'h2000_0000;
        tick();
        cfg_wr = 1'b0;
        chk("ovw_busy", cfg_busy, 1'b1);
        tick();
        chk("ovw_busy_clr", cfg_busy, 1'b0);
        cfg_wr = 1'b1; cfg_sel = 3'd5; cfg_inc = 32'h0;
        seq16 = '0;
        for (int k = 5; k <= 20; k++) begin
            tick();
            if (k == 5) cfg_wr = 1'b0;
            seq16 = {seq16[14:0], cen[1]};
        end
        chk("ovw_seq", seq16, 16'b0000001000000010);
        for (int k = 21; k <= 1028; k++) begin
            tick();
            if (k == 1027) chk("ovw_lock_1027", locked, 1'b0);
            if (k == 1028) chk("ovw_lock_1028", locked, 1'b1);
        end

        // Stop ch1
        cfg_wr = 1'b1; cfg_sel = 3'd1; cfg_inc = 32'h0;
        tick();
        cfg_wr = 1'b0;
        chk("stop_locked", locked, 1'b0);
        chk("stop_busy", cfg_busy, 1'b1);
        for (int k = 1030; k <= 1035; k++) tick();
        chk("stop_last_pulse", cen[1], 1'b1);
        chk("stop_busy_clr", cfg_busy, 1'b0);
        cnt = 0;
        for (int k = 1036; k <= 2059; k++) begin
            tick();
            cnt += int'(cen[1]);
            if (k == 2058) chk("stop_lock_2058", locked, 1'b0);
            if (k == 2059) chk("stop_lock_2059", locked, 1'b1);
        end
        chk("stop_pulses", cnt, 0);

        // Out-of-range write while locked
        cfg_wr = 1'b1; cfg_sel = 3'd5; cfg_inc = 32'h8000_0000;
        tick();
        cfg_wr = 1'b0;
        chk("sel5_busy", cfg_busy, 1'b0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            cnt += int'(cen[1]);
        end
        chk("sel5_ch1", cnt, 0);
        chk("sel5_locked", locked, 1'b1);

        // Restart a stopped channel: applies on the next cycle
        cfg_wr = 1'b1; cfg_sel = 3'd1; cfg_inc = 32'h8000_0000;
        tick();
        cfg_wr = 1'b0;
        chk("restart_busy", cfg_busy, 1'b1);
        tick();
        chk("restart_busy_clr", cfg_busy, 1'b0);
        tick();
        chk("restart_y2", cen[1], 1'b0);
        tick();
        chk("restart_y3", cen[1], 1'b1);

        // Reset with a write pending
        cfg_wr = 1'b1; cfg_sel = 3'd0; cfg_inc = 32'h1000_0000;
        tick();
        cfg_wr = 1'b0;
        chk("pre_rst_busy", cfg_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", cfg_busy, 1'b0);
        chk("mid_rst_cen", cen, 2'b00);
        tick(); tick();
        rst_n = 1'b1;
        seq11 = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            seq11 = {seq11[9:0], cen[0]};
        end
        chk("post_rst_ch0", seq11, 11'b0101);
        chk("post_rst_busy", cfg_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
